// File: rtl/t07_cpu_wb_bridge_if.sv
// t07_cpu_wb_bridge_if: Wishbone-classic bus between the t07 bridge (master) and a slave.
// Signals, named from the master's side:
//   cyc, stb, we  cycle / strobe / write enable          (master -> slave)
//   adr[31:0]     word-aligned byte address              (master -> slave)
//   dat_o[31:0]   write data                             (master -> slave)
//   sel[3:0]      byte select                            (master -> slave)
//   dat_i[31:0]   read data                              (slave -> master)
//   ack           acknowledge                            (slave -> master)
interface t07_cpu_wb_bridge_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic [3:0]  sel;
   logic [31:0] dat_i;
   logic        ack;
   modport master (output cyc, stb, we, adr, dat_o, sel, input dat_i, ack);
   modport slave  (input cyc, stb, we, adr, dat_o, sel, output dat_i, ack);
endinterface

// File: rtl/t07_cpu_wb_bridge.sv
// t07_cpu_wb_bridge: turns t07 CPU memory requests into single Wishbone-classic cycles with a timeout.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rwi_i[1:0]          request: 00 idle, 01 write, 10 data read, 11 instruction fetch
//   addr_i, wdata_i     request byte address and write data
//   busy_o              high while a request occupies the bus
//   instr_o, rdata_o    last fetched instruction / last read data
//   err_o               sticky timeout flag
//   wb                  Wishbone master port
module t07_cpu_wb_bridge #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             rwi_i,
   input  logic [31:0]            addr_i,
   input  logic [31:0]            wdata_i,
   output logic                   busy_o,
   output logic [31:0]            instr_o,
   output logic [31:0]            rdata_o,
   output logic                   err_o,
   t07_cpu_wb_bridge_if.master    wb
);
   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
   state_t      state_q, state_d;
   logic [1:0]  rwi_q, rwi_d;
   logic [31:0] adr_q, adr_d, dat_q, dat_d, instr_q, instr_d, rdata_q, rdata_d;
   logic        cyc_q, cyc_d, we_q, we_d, busy_q, busy_d, err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic        expire;
   // cnt_q counts completed ack-less BUS cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1
   assign expire = cnt_q == CNT_LAST;
   always_comb begin
      state_d = state_q;
      rwi_d   = rwi_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      busy_d  = busy_q;
      instr_d = instr_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (rwi_i != 2'b00) begin
            state_d = BUS;
            rwi_d   = rwi_i;
            adr_d   = {addr_i[31:2], 2'b00};
            dat_d   = wdata_i;
            cyc_d   = 1'b1;
            we_d    = rwi_i == 2'b01;
            busy_d  = 1'b1;
            cnt_d   = '0;
         end
         BUS: if (wb.ack || expire) begin
            // ack wins over a simultaneous expiry
            state_d = DONE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            instr_d = rwi_q == 2'b11 ? (wb.ack ? wb.dat_i : ERR_DATA) : instr_q;
            rdata_d = rwi_q == 2'b10 ? (wb.ack ? wb.dat_i : ERR_DATA) : rdata_q;
            err_d   = err_q | ~wb.ack;
         end else begin
            cnt_d   = cnt_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rwi_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         instr_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rwi_q   <= rwi_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         instr_q <= instr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   assign busy_o   = busy_q;
   assign instr_o  = instr_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign wb.cyc   = cyc_q;
   assign wb.stb   = cyc_q;
   assign wb.we    = we_q;
   assign wb.adr   = adr_q;
   assign wb.dat_o = dat_q;
   // full-word select whenever a cycle is active; zero out of reset like every other output
   assign wb.sel   = {4{cyc_q}};
endmodule

// File: tb/tb_t07_cpu_wb_bridge.sv
// tb_t07_cpu_wb_bridge: directed scoreboard bench for the t07 CPU Wishbone bridge.
module tb_t07_cpu_wb_bridge;
   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   typedef struct {
      logic [31:0] instr;
      logic [31:0] rdata;
      logic        err;
      int          busy;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  rwi_i = 2'b00;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        busy_o, err_o;
   logic [31:0] instr_o, rdata_o;
   int          checks = 0;
   int          fails = 0;
   int          ack_delay = -1;
   int          bus_cnt = 0;
   logic        force_ack = 1'b0;
   logic [31:0] sdata = '0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_rdata = '0;
   logic        m_err = 1'b0;
   exp_t        sb[$];
   t07_cpu_wb_bridge_if wbi ();
   t07_cpu_wb_bridge #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst(rst), .rwi_i(rwi_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .busy_o(busy_o), .instr_o(instr_o), .rdata_o(rdata_o), .err_o(err_o), .wb(wbi.master)
   );
   always #5 clk = ~clk;
   // slave: ack after ack_delay cycles of an active cycle (never if negative); force_ack pulses ack regardless
   initial begin
      wbi.ack   = 1'b0;
      wbi.dat_i = '0;
      forever begin
         @(negedge clk);
         #1;
         wbi.dat_i = sdata;
         if (wbi.cyc === 1'b1) begin
            wbi.ack = force_ack || (ack_delay >= 0 && bus_cnt == ack_delay);
            bus_cnt++;
         end else begin
            wbi.ack = force_ack;
            bus_cnt = 0;
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic req(input logic [1:0] rwi, input logic [31:0] a, input logic [31:0] w,
                      input int dly, input logic [31:0] sd);
      exp_t e;
      int   n;
      logic ok;
      ok = dly >= 0 && dly < TO;
      if (rwi == 2'b11) m_instr = ok ? sd : ERR;
      if (rwi == 2'b10) m_rdata = ok ? sd : ERR;
      if (!ok) m_err = 1'b1;
      e = '{m_instr, m_rdata, m_err, ok ? dly + 1 : TO};
      sb.push_back(e);
      @(negedge clk);
      rwi_i = rwi; addr_i = a; wdata_i = w; ack_delay = dly; sdata = sd;
      @(negedge clk);
      rwi_i = 2'b00;
      n = 0;
      while (busy_o === 1'b1 && n < 40) begin
         chk("bus_cyc", 32'(wbi.cyc), 32'd1);
         chk("bus_stb", 32'(wbi.stb), 32'd1);
         chk("bus_adr", wbi.adr, {a[31:2], 2'b00});
         chk("bus_we", 32'(wbi.we), 32'(rwi == 2'b01));
         chk("bus_dat", wbi.dat_o, w);
         chk("bus_sel", 32'(wbi.sel), 32'hF);
         n++;
         @(negedge clk);
      end
      e = sb.pop_front();
      chk("busy_len", 32'(n), 32'(e.busy));
      chk("instr", instr_o, e.instr);
      chk("rdata", rdata_o, e.rdata);
      chk("err", 32'(err_o), 32'(e.err));
      chk("cyc_after", 32'(wbi.cyc), 32'd0);
      chk("stb_after", 32'(wbi.stb), 32'd0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_cyc", 32'(wbi.cyc), 32'd0);
      chk("rst_sel", 32'(wbi.sel), 32'd0);
      rst = 1'b0;
      req(2'b11, 32'h0000_0104, 32'h0, 3, 32'h0000_0093);
      req(2'b01, 32'h0000_2003, 32'hCAFE_F00D, 0, 32'h1111_1111);
      req(2'b10, 32'h0000_3000, 32'h0, 3, 32'h1234_5678);
      req(2'b10, 32'h0000_4000, 32'h0, -1, 32'h5555_5555);
      req(2'b10, 32'h0000_4004, 32'h0, 1, 32'h0BAD_F00D);
      req(2'b11, 32'h0000_0200, 32'h0, -1, 32'h7777_7777);
      // held request: rwi stays nonzero through completion, changes mid-cycle are not seen on the bus
      @(negedge clk);
      rwi_i = 2'b10; addr_i = 32'h0000_0300; ack_delay = 1; sdata = 32'hA5A5_0001;
      @(negedge clk);
      rwi_i = 2'b11; addr_i = 32'h0000_0502;
      chk("held_adr1", wbi.adr, 32'h0000_0300);
      chk("held_we1", 32'(wbi.we), 32'd0);
      @(negedge clk);
      chk("held_adr2", wbi.adr, 32'h0000_0300);
      chk("held_busy2", 32'(busy_o), 32'd1);
      @(negedge clk);
      chk("held_done_busy", 32'(busy_o), 32'd0);
      chk("held_done_cyc", 32'(wbi.cyc), 32'd0);
      chk("held_rdata", rdata_o, 32'hA5A5_0001);
      sdata = 32'hA5A5_0002;
      @(negedge clk);
      chk("held_idle_cyc", 32'(wbi.cyc), 32'd0);
      @(negedge clk);
      rwi_i = 2'b00;
      chk("held_second_cyc", 32'(wbi.cyc), 32'd1);
      chk("held_second_adr", wbi.adr, 32'h0000_0500);
      chk("held_second_busy", 32'(busy_o), 32'd1);
      repeat (2) @(negedge clk);
      chk("held_instr", instr_o, 32'hA5A5_0002);
      chk("held_rdata_keep", rdata_o, 32'hA5A5_0001);
      // reset while waiting on a silent slave, then a stray ack
      @(negedge clk);
      rwi_i = 2'b10; addr_i = 32'h0000_0600; ack_delay = -1; sdata = 32'h9999_9999;
      @(negedge clk);
      rwi_i = 2'b00;
      @(negedge clk);
      chk("mid_cyc", 32'(wbi.cyc), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_cyc", 32'(wbi.cyc), 32'd0);
      chk("mr_stb", 32'(wbi.stb), 32'd0);
      chk("mr_busy", 32'(busy_o), 32'd0);
      chk("mr_err", 32'(err_o), 32'd0);
      chk("mr_instr", instr_o, 32'd0);
      chk("mr_rdata", rdata_o, 32'd0);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("late_ack_rdata", rdata_o, 32'd0);
      chk("late_ack_busy", 32'(busy_o), 32'd0);
      chk("late_ack_cyc", 32'(wbi.cyc), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
